// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
// The slave modport is the loader side; the master modport is the stream source / system side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
  );

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: parses a 16-bit word count, then writes big-endian words into instruction memory.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK    = 3'd5,
`endif
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FINISH = CHK;
`else
  localparam state_t FINISH = DONE;
`endif

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  state_t            state_r;
  state_t            next_s;
  logic [15:0]       count_r;
  logic [15:0]       hdr_n_s;
  logic [ADDR_W:0]   word_cnt_r;
  logic [1:0]        byte_idx_r;
  logic [23:0]       asm_r;
  logic              accept_s;
  logic              last_word_s;
  logic              ready_r;
  logic              done_r;
  logic              error_r;
  logic              hold_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        xor_r;
`endif

  assign accept_s    = bus.byte_valid && ready_r;
  assign last_word_s = ({1'b0, count_r} == (17'(word_cnt_r) + 17'd1));

  assign bus.byte_ready = ready_r;
  assign bus.done       = done_r;
  assign bus.error      = error_r;
  assign bus.cpu_hold   = hold_r;
  assign bus.imem_we    = we_r;
  assign bus.imem_addr  = addr_r;
  assign bus.imem_wdata = wdata_r;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_s  = state_r;
    hdr_n_s = {count_r[15:8], bus.byte_data};
    case (state_r)
      IDLE: begin
        if (bus.start) next_s = HDR_HI;
        else           next_s = IDLE;
      end
      HDR_HI: begin
        if (accept_s) next_s = HDR_LO;
        else          next_s = HDR_HI;
      end
      HDR_LO: begin
        if (!accept_s)                     next_s = HDR_LO;
        else if (hdr_n_s == 16'd0)         next_s = FINISH;
        else if ({1'b0, hdr_n_s} > CAPACITY) next_s = ERR;
        else                               next_s = DATA;
      end
      DATA: begin
        if (accept_s && (byte_idx_r == 2'd3)) next_s = WRITE;
        else                                  next_s = DATA;
      end
      WRITE: begin
        if (last_word_s) next_s = FINISH;
        else             next_s = DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (!accept_s)                  next_s = CHK;
        else if (bus.byte_data == xor_r) next_s = DONE;
        else                            next_s = ERR;
      end
`endif
      DONE, ERR: begin
        if (bus.start) next_s = HDR_HI;
        else           next_s = state_r;
      end
      default: next_s = IDLE;
    endcase
  end

  // Status outputs registered from the upcoming state so they track the state register exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_r <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
      hold_r  <= 1'b1;
    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      ready_r <= (next_s == HDR_HI) || (next_s == HDR_LO) || (next_s == DATA) || (next_s == CHK);
`else
      ready_r <= (next_s == HDR_HI) || (next_s == HDR_LO) || (next_s == DATA);
`endif
      done_r  <= (next_s == DONE);
      error_r <= (next_s == ERR);
      hold_r  <= (next_s != DONE);
    end
  end

  // Header capture, word assembly, word index and memory write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r    <= 16'd0;
      word_cnt_r <= '0;
      byte_idx_r <= 2'd0;
      asm_r      <= 24'd0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_r      <= 8'd0;
`endif
    end else begin
      we_r <= 1'b0;
      case (state_r)
        IDLE, DONE, ERR: begin
          if (bus.start) begin
            word_cnt_r <= '0;
            byte_idx_r <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_r      <= 8'd0;
`endif
          end
        end
        HDR_HI: begin
          if (accept_s) count_r[15:8] <= bus.byte_data;
        end
        HDR_LO: begin
          if (accept_s) count_r[7:0] <= bus.byte_data;
        end
        DATA: begin
          if (accept_s) begin
            asm_r      <= {asm_r[15:0], bus.byte_data};
            byte_idx_r <= byte_idx_r + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_r      <= xor_r ^ bus.byte_data;
`endif
            // First byte received sits in bits [31:24]
            if (byte_idx_r == 2'd3) begin
              we_r    <= 1'b1;
              addr_r  <= word_cnt_r[ADDR_W-1:0];
              wdata_r <= {asm_r, bus.byte_data};
            end
          end
        end
        WRITE: begin
          word_cnt_r <= word_cnt_r + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that fills the instruction memory read by the processor's fetch path. It parses a length header, assembles big-endian 32-bit instruction words from a handshaked byte stream, and issues one write per word into instruction memory. It holds the processor in reset (`cpu_hold`) until a load completes successfully.

## Interface

Parameters:
- `ADDR_W`, default 8: word-address width of the instruction memory; capacity is `2**ADDR_W` words.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a load session.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word index for the write.
- `imem_wdata`  out  32  instruction word.
- `cpu_hold`  out  1  drives the processor `reset`; high while not loaded.
- `done`  out  1  load finished successfully.
- `error`  out  1  load aborted.

## Operation

- Stream format: 2-byte word count N (MSB first), then N words of 4 bytes each, MSB first. The first byte of each word lands in bits [31:24], so the opcode field [31:26] arrives first.
- States:
  - `IDLE`: `start` goes to `HDR_HI`.
  - `HDR_HI` / `HDR_LO`: capture N[15:8] and then N[7:0].
  - After `HDR_LO`:
    - N == 0 goes to `DONE` (or `CHK` if the macro is enabled).
    - N > 2**ADDR_W goes to `ERR`.
    - Otherwise goes to `DATA`.
  - `DATA`: shifts bytes into a 32-bit assembly register. The 4th byte goes to `WRITE`.
  - `WRITE`: `imem_we` = 1 for exactly one cycle. Word index increments afterward. The last word goes to `DONE` (or `CHK`); otherwise returns to `DATA`.
  - `DONE` / `ERR`: terminal; `start` restarts at `HDR_HI` with the word index cleared to 0.
- Word index starts at 0 per session and is `ADDR_W+1` bits wide internally, so N == 2**ADDR_W loads fully without wrap.
- `start` is ignored in every state except `IDLE`, `DONE` and `ERR`.
- Outputs:
  - `cpu_hold` = 0 only in `DONE`, and 1 everywhere else (including `ERR`).
  - `done` = (state == `DONE`).
  - `error` = (state == `ERR`).

## Timing

- A byte is transferred on a rising edge where `byte_valid && byte_ready`.
- `byte_ready` is a registered-state decode:
  - 1 in `HDR_HI`, `HDR_LO`, `DATA` and `CHK`.
  - 0 in `IDLE`, `WRITE`, `DONE` and `ERR`.
- `byte_ready` does not depend on `byte_valid`.
- Source may deassert `byte_valid` at any time; the loader stalls without losing state.
- `start` sampled high in `IDLE` gives `byte_ready` = 1 on the next cycle.
- `imem_we`, `imem_addr` and `imem_wdata` are registered and valid in the cycle after the 4th byte is accepted.
- Minimum 5 cycles per word (4 accept + 1 write).
- `done` / `error` assert the cycle after the final deciding byte (or after the last `WRITE`).
- Reset values:
  - State `IDLE`.
  - `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `byte_ready` = 0, `done` = 0, `error` = 0.
  - `cpu_hold` = 1.
- Reset mid-load:
  - Immediate return to `IDLE` with no write of the partial word.
  - Words already written remain in memory.
  - `cpu_hold` stays 1.

## Configuration

- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the last data byte (or after the header when N == 0), state `CHK` accepts one trailing byte.
  - Match against the XOR of all 4N data bytes (0x00 when N == 0): match goes to `DONE`, mismatch goes to `ERR`.
  - Already-written words are not rolled back.
- Undefined: no `CHK` state, no trailing byte, and the XOR register is not built.

## Test plan

- Two-word load: `start`, bytes 00 02 8C 22 00 04 01 23 45 67 with `byte_valid` held high. Expect:
  - Writes addr 0 = 0x8C220004 and addr 1 = 0x01234567, each with `imem_we` high for one cycle.
  - `byte_ready` = 0 in each write cycle.
  - Then `done` = 1 and `cpu_hold` = 0.
- Empty program: header 00 00. Expect `done` = 1 the cycle after the 2nd byte, no `imem_we` pulse (macro off).
- Overflow with `ADDR_W` = 8: header 01 01 (257 words). Expect `error` = 1, `byte_ready` = 0 thereafter, `cpu_hold` = 1, no writes. A subsequent `start` re-enters `HDR_HI`.
- Stall robustness: the two-word stream from the first case with random `byte_valid` gaps of 0–3 cycles. Expect identical writes and addresses.
- Reset mid-load: assert `reset` after 2 bytes of word 1. Expect `IDLE`, all outputs at reset values, no write at addr 1. A fresh load then starts at addr 0.
- Checksum (macro on): stream 00 01 11 22 33 44 plus trailing 0x44 (XOR of the four data bytes) gives `done`; trailing 0x45 gives `error`. In both cases the write of 0x11223344 occurs.
